// File: rtl/sync_fifo_param_if.sv
// Handshake/data bundle between sync_fifo_param and its producer/consumer logic.
interface sync_fifo_param_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 64
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                  clr;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CNT_W-1:0]      count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clr, wr_en, din, rd_en,
        input  dout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  clr, wr_en, din, rd_en,
        output dout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through output; default is a registered read.
module sync_fifo_param #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned AF_THRESH  = 60,
    parameter int unsigned AE_THRESH  = 4
) (
    input logic              clk,
    input logic              rst_n,
    sync_fifo_param_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_nxt;
    logic                  full_q;
    logic                  empty_q;
    logic                  af_q;
    logic                  ae_q;
    logic                  ovf_q;
    logic                  unf_q;
    logic                  wr_acc;
    logic                  rd_acc;

    // Acceptance uses only registered flags, so rd_en never gates a write combinationally.
    always_comb begin
        wr_acc    = bus.wr_en & ~full_q  & ~bus.clr;
        rd_acc    = bus.rd_en & ~empty_q & ~bus.clr;
        count_nxt = count_q;
        if (bus.clr)
            count_nxt = '0;
        else if (wr_acc & ~rd_acc)
            count_nxt = count_q + CNT_W'(1);
        else if (rd_acc & ~wr_acc)
            count_nxt = count_q - CNT_W'(1);
    end

    // Flags are derived from the next count so they line up with the registered count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_nxt;
            full_q  <= (count_nxt == CNT_W'(DEPTH));
            empty_q <= (count_nxt == '0);
            af_q    <= (count_nxt >= CNT_W'(AF_THRESH));
            ae_q    <= (count_nxt <= CNT_W'(AE_THRESH));
            if (bus.clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                ovf_q  <= 1'b0;
                unf_q  <= 1'b0;
            end else begin
                if (wr_acc)
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                if (rd_acc)
                    rd_ptr <= rd_ptr + ADDR_W'(1);
                if (bus.wr_en & full_q)
                    ovf_q <= 1'b1;
                if (bus.rd_en & empty_q)
                    unf_q <= 1'b1;
            end
        end
    end

    // Storage array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= bus.din;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign bus.dout       = mem[rd_ptr];
    assign bus.dout_valid = ~empty_q;
`else
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  dout_valid_q;

    // dout holds the last popped word; dout_valid pulses once per accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= rd_acc;
            if (rd_acc)
                dout_q <= mem[rd_ptr];
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
`endif

    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: directed vector table plus queue-model sequences.
module tb_sync_fifo_param;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned AF    = 60;
    localparam int unsigned AE    = 4;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    sync_fifo_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    sync_fifo_param #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0] q[$];
    logic          m_ov;
    logic          m_un;
    logic          m_dv;
    logic [DW-1:0] m_dout;

    typedef struct {
        logic          clr;
        logic          wr;
        logic          rd;
        logic [DW-1:0] din;
        int            cnt;
        logic          full;
        logic          empty;
        logic          af;
        logic          ae;
        logic          ov;
        logic          un;
        logic          dv;
        logic [DW-1:0] dout;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic w, input logic r, input logic [DW-1:0] d);
        bus.clr   = c;
        bus.wr_en = w;
        bus.rd_en = r;
        bus.din   = d;
        @(posedge clk);
        #1;
        bus.clr   = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        m_ov   = 1'b0;
        m_un   = 1'b0;
        m_dv   = 1'b0;
        m_dout = '0;
    endtask

    task automatic model_step(input logic c, input logic w, input logic r, input logic [DW-1:0] d);
        int  n;
        bit  wa;
        bit  ra;
        n = q.size();
        if (c) begin
            q.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
            m_dv = 1'b0;
        end else begin
            wa = w && (n != DEPTH);
            ra = r && (n != 0);
            if (w && n == DEPTH) m_ov = 1'b1;
            if (r && n == 0)     m_un = 1'b1;
            m_dv = ra;
            if (ra) m_dout = q.pop_front();
            if (wa) q.push_back(d);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"},     32'(bus.count),        32'(n));
        chk({tag, ".full"},      32'(bus.full),         32'(n == DEPTH));
        chk({tag, ".empty"},     32'(bus.empty),        32'(n == 0));
        chk({tag, ".afull"},     32'(bus.almost_full),  32'(n >= AF));
        chk({tag, ".aempty"},    32'(bus.almost_empty), 32'(n <= AE));
        chk({tag, ".overflow"},  32'(bus.overflow),     32'(m_ov));
        chk({tag, ".underflow"}, 32'(bus.underflow),    32'(m_un));
`ifdef SYNC_FIFO_FWFT_EN
        chk({tag, ".dout_valid"}, 32'(bus.dout_valid), 32'(n != 0));
        if (n != 0) chk({tag, ".dout"}, 32'(bus.dout), 32'(q[0]));
`else
        chk({tag, ".dout_valid"}, 32'(bus.dout_valid), 32'(m_dv));
        chk({tag, ".dout"},       32'(bus.dout),       32'(m_dout));
`endif
    endtask

    task automatic step(input logic c, input logic w, input logic r, input logic [DW-1:0] d,
                        input string tag);
        drive(c, w, r, d);
        model_step(c, w, r, d);
        check_all(tag);
    endtask

    initial begin
        bus.clr   = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.din   = '0;
        rst_n     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifndef SYNC_FIFO_FWFT_EN
        //            clr wr rd din    cnt fu em af ae ov un dv dout
        vecs[0] = '{1'b0,1'b0,1'b1,8'h00, 0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,8'h00};
        vecs[1] = '{1'b0,1'b1,1'b1,8'h55, 1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,8'h00};
        vecs[2] = '{1'b0,1'b1,1'b0,8'h66, 2,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,8'h00};
        vecs[3] = '{1'b0,1'b0,1'b1,8'h00, 1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,8'h55};
        vecs[4] = '{1'b0,1'b0,1'b0,8'h00, 1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,8'h55};
        vecs[5] = '{1'b0,1'b1,1'b1,8'h77, 1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,8'h66};
        vecs[6] = '{1'b1,1'b1,1'b0,8'h88, 0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,8'h66};
        vecs[7] = '{1'b0,1'b0,1'b1,8'h00, 0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,8'h66};
        vecs[8] = '{1'b1,1'b0,1'b0,8'h00, 0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,8'h66};
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].clr, vecs[i].wr, vecs[i].rd, vecs[i].din);
            chk($sformatf("vec%0d.count", i),     32'(bus.count),        32'(vecs[i].cnt));
            chk($sformatf("vec%0d.full", i),      32'(bus.full),         32'(vecs[i].full));
            chk($sformatf("vec%0d.empty", i),     32'(bus.empty),        32'(vecs[i].empty));
            chk($sformatf("vec%0d.afull", i),     32'(bus.almost_full),  32'(vecs[i].af));
            chk($sformatf("vec%0d.aempty", i),    32'(bus.almost_empty), 32'(vecs[i].ae));
            chk($sformatf("vec%0d.overflow", i),  32'(bus.overflow),     32'(vecs[i].ov));
            chk($sformatf("vec%0d.underflow", i), 32'(bus.underflow),    32'(vecs[i].un));
            chk($sformatf("vec%0d.dv", i),        32'(bus.dout_valid),   32'(vecs[i].dv));
            chk($sformatf("vec%0d.dout", i),      32'(bus.dout),         32'(vecs[i].dout));
        end
        // Table ends with a clear: FIFO empty, flags clear, dout retained
        q.delete();
        m_ov   = 1'b0;
        m_un   = 1'b0;
        m_dv   = 1'b0;
        m_dout = 8'h66;
`endif

        // Fill to full, then overflow attempt
        for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 1'b0, 8'(i), $sformatf("fill%0d", i));
        step(1'b0, 1'b1, 1'b0, 8'hAA, "ovf_write");
        step(1'b0, 1'b1, 1'b1, 8'hAB, "full_rw");
        step(1'b0, 1'b1, 1'b0, 8'hAC, "refill");

        // Drain everything in order
        for (int i = 0; i < 64; i++) step(1'b0, 1'b0, 1'b1, 8'h00, $sformatf("drain%0d", i));

        // Underflow, then simultaneous read/write on empty
        step(1'b0, 1'b0, 1'b1, 8'h00, "unf_read");
        step(1'b0, 1'b1, 1'b1, 8'h55, "empty_rw");
        step(1'b0, 1'b0, 1'b1, 8'h00, "pop55");
        step(1'b1, 1'b0, 1'b0, 8'h00, "clr1");

        // Steady state at 32 with pointer wrap
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 1'b0, 8'(i), $sformatf("half%0d", i));
        for (int i = 0; i < 100; i++)
            step(1'b0, 1'b1, 1'b1, 8'(32 + i), $sformatf("stream%0d", i));
        chk("stream.count32", 32'(bus.count), 32'd32);

        // Overflow at full, drain to 10, then clear alongside a write
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 1'b0, 8'(200 + i), $sformatf("top%0d", i));
        step(1'b0, 1'b1, 1'b0, 8'hAA, "ovf2");
        for (int i = 0; i < 54; i++) step(1'b0, 1'b0, 1'b1, 8'h00, $sformatf("dn%0d", i));
        chk("pre_clr.count10", 32'(bus.count), 32'd10);
        step(1'b1, 1'b1, 1'b0, 8'hEE, "clr_wr");
        step(1'b0, 1'b0, 1'b0, 8'h00, "post_clr");

        // Asynchronous reset in the middle of a write burst
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(90 + i), $sformatf("burst%0d", i));
        bus.wr_en = 1'b1;
        bus.din   = 8'h99;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        bus.wr_en = 1'b0;
        @(posedge clk);
        #1;
        check_all("rst_held");
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'h00, "rst_release");

        // Single word into an empty FIFO, then pop it
        step(1'b0, 1'b1, 1'b0, 8'h11, "w11");
        step(1'b0, 1'b0, 1'b0, 8'h00, "idle11");
        step(1'b0, 1'b0, 1'b1, 8'h00, "pop11");
        chk("pop11.empty", 32'(bus.empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO, next generation of the team's 8-bit/64-deep synchronous FIFO. Adds generic width and depth, an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and a read-data valid strobe. Sits between producer and consumer logic in the same clock domain, for example stream buffers and command queues.

Parameters:
DATA_WIDTH, 8, width of din/dout in bits (>=1)
DEPTH, 64, number of entries; must be a power of 2, >=4
AF_THRESH, 60, almost_full asserted when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 4, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
ADDR_W (localparam), $clog2(DEPTH), pointer width; count is ADDR_W+1 bits

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous flush, active-high
wr_en  in  1  write request
din  in  DATA_WIDTH  write data
rd_en  in  1  read request
dout  out  DATA_WIDTH  read data
dout_valid  out  1  dout holds newly popped data (registered mode)
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, dout=0, dout_valid=0, full=0, empty=1, almost_full=0, almost_empty=1 (AE_THRESH>=0), overflow=0, underflow=0. Memory is not reset. Reset asserted mid-operation discards all contents. Deassertion takes effect at the next clk edge.
- Accept rules, evaluated on flag values before the edge: wr_acc = wr_en & !full; rd_acc = rd_en & !empty. No combinational path from rd_en to write acceptance.
- wr_acc: mem[wr_ptr] <= din; wr_ptr increments modulo DEPTH (natural wrap).
- rd_acc: rd_ptr increments modulo DEPTH.
- count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither. Never exceeds DEPTH and never underflows.
- All flags are registered and computed from the next value of count, so they are valid in the same cycle as the updated count. Write at count 63 gives full=1 the following cycle; read at count 1 gives empty=1 the following cycle.
- Simultaneous rd_en & wr_en:
  - empty: only the write is accepted; underflow is set.
  - full: only the read is accepted; the write is dropped and overflow is set.
  - otherwise: both are accepted and count is unchanged.
- Read data latency (default mode): on rd_acc, dout <= mem[rd_ptr] and dout_valid=1 on the next cycle. dout_valid=0 on any cycle without rd_acc. dout holds its last value.
- overflow is set when wr_en & full; underflow is set when rd_en & empty. Both stay high until clr or reset.
- clr: same-edge effect equal to reset on pointers, count, flags, overflow, underflow and dout_valid. dout is retained. clr has priority over any concurrent wr_en/rd_en, which are ignored in that cycle.
- Read-during-write of the same address cannot occur in registered mode, because a read requires !empty and writes never target an unread entry.

Optional Feature:
Macro SYNC_FIFO_FWFT_EN (first-word fall-through).
- Defined:
  - dout is driven combinationally from mem[rd_ptr] and dout_valid = !empty.
  - rd_en acts as a pop/acknowledge of the displayed word.
  - Write-to-dout latency is one cycle: a word written at edge N is visible after edge N. A simultaneous write to an empty FIFO is visible after that edge.
  - dout reset value is don't-care; dout_valid resets to 0.
- Undefined: registered read with the 1-cycle latency described above (default).

Test Plan:
- Reset, then write 64 words 0x00..0x3F -> full=1 after the 64th write; count=64; almost_full=1 from count=60; overflow=0.
- With the FIFO full, apply wr_en and din=0xAA -> write dropped, overflow=1 (sticky), count=64. Read 64 -> dout 0x00..0x3F in order, each with dout_valid one cycle after rd_en, then empty=1.
- Empty FIFO, rd_en=1 -> underflow=1, count=0, dout_valid=0. Hold rd_en=1 with wr_en=1 and din=0x55 -> write accepted, count=1, underflow stays 1.
- Count=32, continuous rd_en & wr_en for 100 cycles with an incrementing pattern -> count stays 32, pointers wrap, output order is preserved with no gaps.
- Count=10 with overflow=1, pulse clr alongside wr_en -> count=0, empty=1, overflow=0, write ignored. Drop rst_n mid-burst -> all outputs return to their reset values immediately, asynchronously.
- SYNC_FIFO_FWFT_EN build: write 0x11 into an empty FIFO -> dout=0x11 and dout_valid=1 the next cycle with no rd_en. Assert rd_en -> empty=1, dout_valid=0.
